dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the control-unit datapath (CPU port: D_addr/D_wr,
//  write data from RF A-side) and a host/loader port used to preload or inspect memory.
//  Fixed CPU priority with a starvation guard for the host, plus a host lock mode for burst loads.
//  Sits between the control unit / register file and the data RAM (1-cycle synchronous read).
// PARAMETERS
//  ADDR_W        8   data memory address width
//  DATA_W        16  data word width
//  STARVE_LIMIT  4   consecutive CPU wins over a waiting host before host gets priority (>=1)
// PORTS
//  Clk          in   1       system clock, all logic on posedge
//  Reset        in   1       synchronous, active-high reset
//  cpu_req      in   1       CPU access request; held until cpu_gnt
//  cpu_wr       in   1       1 = write, 0 = read
//  cpu_addr     in   ADDR_W  CPU address
//  cpu_wdata    in   DATA_W  CPU write data
//  cpu_gnt      out  1       CPU access issued to memory this cycle
//  cpu_rvalid   out  1       cpu read data valid on rdata (cycle after read grant)
//  host_req     in   1       host access request; held until host_gnt
//  host_wr      in   1       1 = write, 0 = read
//  host_addr    in   ADDR_W  host address
//  host_wdata   in   DATA_W  host write data
//  host_lock    in   1       hold memory for host across a burst
//  host_gnt     out  1       host access issued this cycle
//  host_rvalid  out  1       host read data valid on rdata
//  rdata        out  DATA_W  mem_rdata passthrough (shared by both ports)
//  mem_addr     out  ADDR_W  RAM address
//  mem_wr       out  1       RAM write enable
//  mem_wdata    out  DATA_W  RAM write data
//  mem_rdata    in   DATA_W  RAM read data (valid 1 cycle after read address)
//  arb_state    out  3       current arbiter state (arb_state_t), for debug
// BEHAVIOUR
//  - Grant is combinational from requests + registered state; at most one gnt per cycle.
//  - Winner's addr/wr/wdata drive mem_*; no winner -> mem_addr=0, mem_wr=0, mem_wdata=0.
//  - States: CPU_PRI (reset), HOST_PRI, HOST_LOCK.
//  - CPU_PRI: cpu_req -> CPU wins; if host_req also high, starve_cnt++ (saturating);
//    when starve_cnt reaches STARVE_LIMIT on that grant -> next HOST_PRI.
//    only host_req -> host wins, cnt=0; next HOST_LOCK if host_lock else CPU_PRI.
//  - HOST_PRI: host_req -> host wins, cnt=0, next HOST_LOCK if host_lock else CPU_PRI;
//    host_req low -> CPU_PRI rules apply this cycle, next CPU_PRI, cnt=0.
//  - HOST_LOCK: cpu_gnt forced 0; host_gnt=host_req; next = host_lock ? HOST_LOCK : CPU_PRI.
//  - starve_cnt cleared whenever host_req=0 or host granted.
//  - Read return: registered tag; cpu_rvalid/host_rvalid pulse exactly 1 cycle after a read
//    grant to that port; writes produce no rvalid. Back-to-back reads give back-to-back rvalids.
//  - Simultaneous read grant in cycle N and new grant in N+1: rvalid of N and gnt of N+1 coexist.
//  - Reset (any cycle): state=CPU_PRI, starve_cnt=0, pending rvalid dropped; all gnt/rvalid/
//    mem_wr=0 while Reset high and in the cycle following its deassertion for rvalid.
//  - Request changing before gnt is illegal; arbiter samples current values only (no buffering).
// STRUCTURE
//  - Shared package ProcDefs: typedef enum logic [2:0] arb_state_t {CPU_PRI, HOST_PRI,
//    HOST_LOCK}; ADDR_W/DATA_W defaults; arb_state_to_string() for benches.
//  - One sub-module: starve_counter (saturating counter, inc/clr, limit-reached flag).
//  - Top: state register, grant logic, mem mux, 2-bit read-tag register.
// TESTING
//  1. Reset high 2 cycles, cpu_req=host_req=1 -> no gnt, mem_wr=0, arb_state=CPU_PRI.
//  2. CPU write addr 8'h10 data 16'hBEEF, then read 8'h10 -> cpu_gnt both cycles,
//     cpu_rvalid=1 next cycle with rdata=16'hBEEF, host_rvalid=0.
//  3. cpu_req and host_req held high -> 4 CPU grants, 5th cycle host_gnt, state back to CPU_PRI.
//  4. host_lock=1, host burst writes 8'h00..8'h03 with cpu_req=1 throughout -> cpu_gnt=0 for
//     all 4 cycles; host_lock=0 -> CPU granted next cycle.
//  5. Host read 8'h03 then Reset asserted in rvalid cycle -> host_rvalid=0, state=CPU_PRI.
//  6. Alternating CPU read / host read every cycle -> rvalid routed to correct port each cycle.

Source files
------------

// File: rtl/ProcDefs.sv
// Shared definitions for the data-memory arbiter: state encoding, default widths,
// and a state-name helper for simulation messages.
package ProcDefs;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    CPU_PRI   = 3'd0,
    HOST_PRI  = 3'd1,
    HOST_LOCK = 3'd2
  } arb_state_t;

  function automatic string arb_state_to_string(arb_state_t s);
    case (s)
      CPU_PRI:   return "CPU_PRI";
      HOST_PRI:  return "HOST_PRI";
      HOST_LOCK: return "HOST_LOCK";
      default:   return "UNKNOWN";
    endcase
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive CPU wins over a waiting host.
// near_limit means one more win brings the count to LIMIT.
module starve_counter #(
  parameter int LIMIT = 4,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic inc,
  input  logic clr,
  output logic near_limit
);

  logic [CNT_W-1:0] cnt;

  // Clear takes precedence over increment; count holds once it reaches LIMIT.
  always_ff @(posedge Clk) begin
    if (Reset || clr)
      cnt <= '0;
    else if (inc && cnt != CNT_W'(LIMIT))
      cnt <= cnt + CNT_W'(1);
  end

  assign near_limit = (cnt >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU datapath and a host/loader port:
// fixed CPU priority, starvation guard for the host, and a host lock for burst loads.
module dmem_arbiter
  import ProcDefs::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        arb_state
);

  arb_state_t state, state_nxt;
  logic       near_limit;
  logic       cnt_inc;
  logic       cnt_clr;
  logic [1:0] rd_tag;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .Clk        (Clk),
    .Reset      (Reset),
    .inc        (cnt_inc),
    .clr        (cnt_clr),
    .near_limit (near_limit)
  );

  // Grants are suppressed entirely while Reset is high.
  always_comb begin
    cpu_gnt   = 1'b0;
    host_gnt  = 1'b0;
    state_nxt = state;
    if (!Reset) begin
      case (state)
        CPU_PRI: begin
          if (cpu_req) begin
            cpu_gnt = 1'b1;
            if (host_req && near_limit)
              state_nxt = HOST_PRI;
          end else if (host_req) begin
            host_gnt  = 1'b1;
            state_nxt = host_lock ? HOST_LOCK : CPU_PRI;
          end
        end
        HOST_PRI: begin
          if (host_req) begin
            host_gnt  = 1'b1;
            state_nxt = host_lock ? HOST_LOCK : CPU_PRI;
          end else begin
            cpu_gnt   = cpu_req;
            state_nxt = CPU_PRI;
          end
        end
        HOST_LOCK: begin
          host_gnt  = host_req;
          state_nxt = host_lock ? HOST_LOCK : CPU_PRI;
        end
        default: state_nxt = CPU_PRI;
      endcase
    end
  end

  assign cnt_inc = cpu_gnt & host_req;
  assign cnt_clr = ~host_req | host_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wr    = cpu_wr;
      mem_wdata = cpu_wdata;
    end else if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wr    = host_wr;
      mem_wdata = host_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= CPU_PRI;
    else
      state <= state_nxt;
  end

  // Tag bit 1 = host read in flight, bit 0 = CPU read in flight.
  always_ff @(posedge Clk) begin
    if (Reset)
      rd_tag <= 2'b00;
    else
      rd_tag <= {host_gnt & ~host_wr, cpu_gnt & ~cpu_wr};
  end

  assign cpu_rvalid  = rd_tag[0] & ~Reset;
  assign host_rvalid = rd_tag[1] & ~Reset;
  assign rdata       = mem_rdata;
  assign arb_state   = state;

endmodule
